// File: rtl/lzc_denorm_pipe.sv
// Denormalizer: rebuilds A = N >> Z through a COUNT-stage pipelined right barrel
// shifter, undoing the normalization done alongside the leading-zero counter.
module lzc_denorm_pipe #(
    parameter int WIDTH = 16,
    parameter int COUNT = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] N,
    input  logic [COUNT:0]   Z,
    input  logic             n_V,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] A,
    output logic             out_err
);

    generate
        if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $fatal(1, "lzc_denorm_pipe: WIDTH must be a power of two >= 2");
        end
    endgenerate

    // Valid/ready: a beat moves on a rising edge when valid and ready are both high;
    // ready never looks at valid, and an offered output holds A/out_err until taken.
    logic [COUNT-1:0] valid_q;
    logic [COUNT-1:0] zero_q;
    logic [COUNT-1:0] err_q;
    logic [WIDTH-1:0] data_q [COUNT];
    logic [COUNT-1:0] zrem_q [COUNT];

    logic [COUNT-1:0] load;
    logic [COUNT-1:0] src_valid;
    logic [COUNT-1:0] src_zero;
    logic [COUNT-1:0] src_err;
    logic [WIDTH-1:0] src_data [COUNT];
    logic [COUNT-1:0] src_z [COUNT];
    logic [WIDTH-1:0] data_d [COUNT];

    // A stage may load when any stage from it to the output is empty, or the output drains.
    always_comb begin : load_chain
        logic full_tail;
        full_tail = 1'b1;
        load      = '0;
        for (int k = COUNT - 1; k >= 0; k--) begin
            full_tail = full_tail & valid_q[k];
            load[k]   = out_ready | ~full_tail;
        end
    end

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = N;
        src_z[0]     = Z[COUNT-1:0];
        src_zero[0]  = ~n_V | Z[COUNT];
        src_err[0]   = n_V & (Z[COUNT] | ~N[WIDTH-1]);
        for (int k = 1; k < COUNT; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_z[k]     = zrem_q[k-1];
            src_zero[k]  = zero_q[k-1];
            src_err[k]   = err_q[k-1];
        end
        for (int k = 0; k < COUNT; k++) begin
            data_d[k] = src_z[k][COUNT-1-k] ? (src_data[k] >> (2 ** (COUNT - 1 - k)))
                                            : src_data[k];
        end
    end

    // Payload only updates alongside a valid beat, so A cannot move while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            zero_q  <= '0;
            err_q   <= '0;
            for (int k = 0; k < COUNT; k++) begin
                data_q[k] <= '0;
                zrem_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < COUNT; k++) begin
                if (load[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        data_q[k] <= data_d[k];
                        zrem_q[k] <= src_z[k];
                        zero_q[k] <= src_zero[k];
                        err_q[k]  <= src_err[k];
                    end
                end
            end
        end
    end

    logic unused_zrem;
    assign unused_zrem = ^zrem_q[COUNT-1];

    assign in_ready  = load[0];
    assign out_valid = valid_q[COUNT-1];
    assign out_err   = err_q[COUNT-1];
    assign A         = zero_q[COUNT-1] ? '0 : data_q[COUNT-1];

endmodule

// File: tb/tb_lzc_denorm_pipe.sv
// Bench for lzc_denorm_pipe: directed vector table, streaming, backpressure,
// async reset mid-stream, and an exhaustive WIDTH=8 round trip.
module tb_lzc_denorm_pipe;

    localparam int W = 16;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid, in_ready, n_v, out_valid, out_ready, out_err;
    logic [W-1:0] n_in, a_out;
    logic [C:0]   z_in;

    logic         in_valid8, in_ready8, n_v8, out_valid8, out_ready8, out_err8;
    logic [7:0]   n8, a8;
    logic [3:0]   z8;

    lzc_denorm_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .N(n_in), .Z(z_in), .n_V(n_v), .out_valid(out_valid),
        .out_ready(out_ready), .A(a_out), .out_err(out_err)
    );

    lzc_denorm_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .N(n8), .Z(z8), .n_V(n_v8), .out_valid(out_valid8),
        .out_ready(out_ready8), .A(a8), .out_err(out_err8)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_acc = 0;
    int           n_out = 0;
    int           n_out8 = 0;
    logic [W:0]   exp_q[$];
    logic [8:0]   exp8_q[$];
    logic         rand_mode = 1'b0;
    logic         hold_pending = 1'b0;
    logic [W:0]   hold_val = '0;
    logic         prev_ov = 1'b1;
    logic [W-1:0] prev_a = '0;
    logic [W:0]   e_v;
    logic [8:0]   e8;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] n, input logic [C:0] z, input logic nv);
        if (!nv) return '0;
        if (z[C]) return {1'b1, {W{1'b0}}};
        return {~n[W-1], n >> z[C-1:0]};
    endfunction

    function automatic logic [3:0] lzc8(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return 4'(7 - i);
        return 4'd8;
    endfunction

    // Random backpressure changes at the falling edge; monitors sample 2ns later.
    always @(negedge clk) if (rand_mode) out_ready = 1'($urandom_range(0, 1));

    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
            prev_ov      = 1'b1;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got A=%0h err=%0b, expected no beat", a_out, out_err);
                end else begin
                    e_v = exp_q.pop_front();
                    check("out_beat", {out_err, a_out}, e_v);
                end
                n_out++;
            end
            if (hold_pending) check("hold_stable", {out_valid, out_err, a_out}, {1'b1, hold_val});
            hold_pending = out_valid && !out_ready;
            hold_val     = {out_err, a_out};
            if (!prev_ov && !out_valid) check("idle_A_stable", a_out, prev_a);
            prev_ov = out_valid;
            prev_a  = a_out;
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp8_q.delete();
        end else if (out_valid8) begin
            if (exp8_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out8: got A=%0h, expected no beat", a8);
            end else begin
                e8 = exp8_q.pop_front();
                check("roundtrip", {out_err8, a8}, e8);
            end
            n_out8++;
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at negedge+3 once the beat is certain to transfer on the next rising edge.
    task automatic send_beat(input logic [W-1:0] n, input logic [C:0] z, input logic nv,
                             input logic [W:0] e, output int waits);
        waits = 0;
        @(negedge clk);
        n_in = n; z_in = z; n_v = nv; in_valid = 1'b1;
        for (int t = 0; t < 500; t++) begin
            #3;
            if (in_ready) begin
                exp_q.push_back(e);
                n_acc++;
                return;
            end
            waits++;
            @(negedge clk);
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic measure_latency(input string name);
        int lat;
        lat = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (t == 0) in_valid = 1'b0;
            #4;
            lat++;
            if (out_valid) break;
        end
        check(name, lat, 4);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [W-1:0] n;
        logic [C:0]   z;
        logic         nv;
        logic [W-1:0] a;
        logic         err;
    } vec_t;

    vec_t vecs[10];
    int   w, w_total, acc_before, out_before, stale;
    logic [W-1:0] rn;
    logic [C:0]   rz;
    logic         rv;
    logic [7:0]   av;
    logic [3:0]   lz;

    initial begin
        vecs[0] = '{16'h8000, 5'd3,  1'b1, 16'h1000, 1'b0};
        vecs[1] = '{16'hB400, 5'd5,  1'b1, 16'h05A0, 1'b0};
        vecs[2] = '{16'h8001, 5'd15, 1'b1, 16'h0001, 1'b0};
        vecs[3] = '{16'hFFFF, 5'd7,  1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h8000, 5'd16, 1'b1, 16'h0000, 1'b1};
        vecs[5] = '{16'h4000, 5'd1,  1'b1, 16'h2000, 1'b1};
        vecs[6] = '{16'h8000, 5'd0,  1'b1, 16'h8000, 1'b0};
        vecs[7] = '{16'hFFFF, 5'd8,  1'b1, 16'h00FF, 1'b0};
        vecs[8] = '{16'h4000, 5'd16, 1'b1, 16'h0000, 1'b1};
        vecs[9] = '{16'h1234, 5'd16, 1'b0, 16'h0000, 1'b0};

        in_valid = 0; n_in = 0; z_in = 0; n_v = 0; out_ready = 1;
        in_valid8 = 0; n8 = 0; z8 = 0; n_v8 = 0; out_ready8 = 1;

        repeat (3) @(negedge clk);
        #4;
        check("reset_out_valid", out_valid, 0);
        check("reset_A", a_out, 0);
        check("reset_out_err", out_err, 0);
        check("reset_out_valid8", out_valid8, 0);
        #3 rst = 1'b0;
        @(negedge clk);
        #4;
        check("ready_after_reset", in_ready, 1);
        check("ready_after_reset8", in_ready8, 1);

        // Directed table, one beat at a time with latency check.
        for (int i = 0; i < 10; i++) begin
            send_beat(vecs[i].n, vecs[i].z, vecs[i].nv, {vecs[i].err, vecs[i].a}, w);
            measure_latency("latency");
        end
        repeat (2) @(negedge clk);
        #4 check("table_drained", exp_q.size(), 0);

        // Back-to-back stream, Z cycling 0..15.
        w_total = 0;
        out_before = n_out;
        for (int i = 0; i < 20; i++) begin
            rn = 16'h8000 | 16'($urandom_range(0, 32767));
            rz = 5'(i % 16);
            send_beat(rn, rz, 1'b1, model(rn, rz, 1'b1), w);
            w_total += w;
        end
        idle();
        @(negedge clk);
        @(negedge clk);
        #4 check("stream_tail_19", n_out - out_before, 19);
        @(negedge clk);
        #4 check("stream_count", n_out - out_before, 20);
        check("stream_in_ready_stalls", w_total, 0);
        check("stream_drained", exp_q.size(), 0);

        // Backpressure: 6 beats against a stalled output.
        @(negedge clk);
        out_ready = 1'b0;
        acc_before = n_acc;
        out_before = n_out;
        fork
            begin : bp_drv
                int wbp;
                for (int i = 0; i < 6; i++) begin
                    rn = 16'hC000 + 16'(i * 3);
                    rz = 5'(i + 1);
                    send_beat(rn, rz, 1'b1, model(rn, rz, 1'b1), wbp);
                end
                idle();
            end
        join_none
        repeat (10) @(negedge clk);
        #1;
        check("bp_accepted", n_acc - acc_before, 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        wait fork;
        repeat (8) @(negedge clk);
        #4;
        check("bp_drain_count", n_out - out_before, 6);
        check("bp_drained", exp_q.size(), 0);

        // Random backpressure with random operands and flags.
        rand_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rn = 16'($urandom_range(0, 65535));
            rz = 5'($urandom_range(0, 16));
            rv = ($urandom_range(0, 3) != 0);
            send_beat(rn, rz, rv, model(rn, rz, rv), w);
        end
        idle();
        for (int t = 0; t < 300 && (exp_q.size() != 0 || out_valid); t++) @(negedge clk);
        rand_mode = 1'b0;
        @(negedge clk);
        #1 out_ready = 1'b1;
        #3 check("rand_drained", exp_q.size(), 0);

        // Asynchronous reset with three beats in flight.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rn = 16'hF000;
            rz = 5'(i);
            send_beat(rn, rz, 1'b1, model(rn, rz, 1'b1), w);
        end
        idle();
        @(negedge clk);
        #4 check("pre_reset_out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_A", a_out, 0);
        check("mid_reset_out_err", out_err, 0);
        #10 rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            #4 if (out_valid) stale++;
        end
        check("no_stale_beat", stale, 0);
        send_beat(16'hA000, 5'd2, 1'b1, model(16'hA000, 5'd2, 1'b1), w);
        measure_latency("latency_after_reset");
        repeat (2) @(negedge clk);
        #4 check("reset_drained", exp_q.size(), 0);

        // Exhaustive round trip at WIDTH=8.
        for (int a = 1; a < 256; a++) begin
            av = 8'(a);
            lz = lzc8(av);
            @(negedge clk);
            n8 = av << lz; z8 = lz; n_v8 = 1'b1; in_valid8 = 1'b1;
            #3;
            check("rt_in_ready", in_ready8, 1);
            exp8_q.push_back({1'b0, av});
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (6) @(negedge clk);
        #4;
        check("rt_count", n_out8, 255);
        check("rt_drained", exp8_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
